alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//   Sequences one ALU operation at a time between a requester and four units: sum, subtract, multiply, divide.
//   Accepts a request (opcode, portA, portB) on a valid/ready handshake, latches the operands and pulses the
//   one-hot init of the selected unit. It then waits for that unit's done, captures the 6-bit result and
//   presents it on a valid/ready response port. Sits between the input/switch logic and the unit datapath.
// PARAMETERS
//   OP_W        3    operand width (portA/portB)
//   RES_W       6    result width per unit
//   TIMEOUT_CYC 64   WAIT-state cycle limit before abort (used only with ALU_SEQ_TIMEOUT_EN)
// PORTS
//   clk          in   1        single clock, all logic on posedge
//   rst          in   1        synchronous, active-high reset
//   req_valid    in   1        request present
//   req_ready    out  1        sequencer can accept a request
//   req_opcode   in   2        00 sum, 01 subtract, 10 multiply, 11 divide
//   req_a        in   OP_W     operand A
//   req_b        in   OP_W     operand B
//   unit_a       out  OP_W     latched operand A, driven to all units
//   unit_b       out  OP_W     latched operand B, driven to all units
//   unit_init    out  4        one-hot init pulse {div,mult,sub,sum}
//   unit_done    in   4        per-unit done {div,mult,sub,sum}, level or pulse
//   unit_res     in   4*RES_W  results {div,mult,sub,sum}; sum in [RES_W-1:0]
//   rsp_valid    out  1        response present
//   rsp_ready    in   1        consumer takes the response
//   rsp_result   out  RES_W    captured result
//   rsp_opcode   out  2        opcode of this response
//   rsp_err      out  1        1 = aborted by timeout; result forced to 0
//   busy         out  1        1 in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE; req_ready=1; unit_init=0; unit_a/unit_b=0; rsp_valid=0; rsp_result=0; rsp_opcode=0;
//     rsp_err=0; busy=0; timeout counter=0. Reset mid-operation aborts at once: no response, no init.
//   FSM (all outputs registered):
//     IDLE : req_ready=1. req_valid&req_ready latches opcode/a/b, then -> ISSUE.
//     ISSUE: unit_init = 1<<opcode for exactly one cycle, then -> WAIT.
//     WAIT : samples unit_done[opcode] only; a done present in the ISSUE cycle is ignored.
//            On done: rsp_result <= unit_res slice[opcode]; rsp_err=0; -> RESP.
//     RESP : rsp_valid=1; result, opcode and err held stable until rsp_valid&rsp_ready, then -> IDLE.
//   Latency: accept at cycle T, init at T+1, done seen at T+k (k>=2), rsp_valid at T+k+1.
//   Back-to-back: req_ready rises the cycle after the response handshake; minimum period is 4 cycles.
//   Handshake: req_ready=0 outside IDLE. unit_a/unit_b hold the latched operands from ISSUE through RESP.
//   Done from a non-selected unit is ignored. A stuck-high done of the selected unit completes WAIT in 1 cycle.
//   rsp_ready held high with no valid response has no effect. An illegal opcode cannot occur (2-bit, full decode).
// CONFIGURATION
//   ALU_SEQ_TIMEOUT_EN defined: WAIT counts cycles from 0. On count == TIMEOUT_CYC-1 with no done:
//     rsp_result=0, rsp_err=1, -> RESP. The counter clears on entry to WAIT.
//     Done arriving in the same cycle as the limit wins (err=0).
//   ALU_SEQ_TIMEOUT_EN undefined: no counter. WAIT waits indefinitely; rsp_err tied 0.
// TESTING
//   1 reset: rst=1 for 2 cycles mid-WAIT -> IDLE next edge; unit_init=0, rsp_valid=0, req_ready=1.
//   2 sum: op=00, a=3, b=5, done[0] 1 cycle after init, res=8
//     -> init=0001 for 1 cycle; rsp_result=8, rsp_opcode=00, rsp_err=0.
//   3 multiply with stall: op=10, a=7, b=7, done[2] after 6 cycles, res=49, rsp_ready low 3 cycles
//     -> rsp_valid held, result=49 stable; no new request accepted.
//   4 wrong done: op=11, a=6, b=2; pulse done[0] then done[3], res div=3
//     -> done[0] ignored; rsp_result=3.
//   5 timeout (EN, TIMEOUT_CYC=64): op=01, done never asserted
//     -> rsp_valid 64 cycles after entering WAIT, rsp_result=0, rsp_err=1; without EN, busy stays 1.
//   6 back-to-back: req_valid held with 4 queued ops, rsp_ready=1 -> each op accepted once, in order,
//     4-cycle minimum spacing, all results correct.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time (sum/sub/mult/div) between a requester and the unit datapath.
// Optional WAIT-state abort timer is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
  parameter int OP_W        = 3,
  parameter int RES_W       = 6,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_opcode,
  input  logic [OP_W-1:0]    req_a,
  input  logic [OP_W-1:0]    req_b,
  output logic [OP_W-1:0]    unit_a,
  output logic [OP_W-1:0]    unit_b,
  output logic [3:0]         unit_init,
  input  logic [3:0]         unit_done,
  input  logic [4*RES_W-1:0] unit_res,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [RES_W-1:0]   rsp_result,
  output logic [1:0]         rsp_opcode,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t     state;
  logic [1:0] op_q;

  function automatic logic [RES_W-1:0] res_slice(input logic [4*RES_W-1:0] res,
                                                 input logic [1:0]         op);
    return res[op*RES_W +: RES_W];
  endfunction

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] to_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      unit_init  <= 4'b0000;
      unit_a     <= '0;
      unit_b     <= '0;
      op_q       <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_opcode <= 2'b00;
      busy       <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      rsp_err    <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_opcode;
            unit_a    <= req_a;
            unit_b    <= req_b;
            // init is registered here so it is visible exactly during the ISSUE cycle
            unit_init <= 4'b0001 << req_opcode;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          unit_init <= 4'b0000;
          state     <= S_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
          to_cnt    <= '0;
`endif
        end
        S_WAIT: begin
          // done wins over a timeout landing in the same cycle
          if (unit_done[op_q]) begin
            rsp_result <= res_slice(unit_res, op_q);
            rsp_opcode <= op_q;
            rsp_valid  <= 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
            rsp_err    <= 1'b0;
`endif
            state      <= S_RESP;
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            rsp_result <= '0;
            rsp_opcode <= op_q;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            state      <= S_RESP;
          end else begin
            to_cnt     <= to_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; the timeout scenario follows ALU_SEQ_TIMEOUT_EN.
module tb_alu_op_sequencer;
  localparam int OP_W  = 3;
  localparam int RES_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_opcode;
  logic [OP_W-1:0]  req_a, req_b;
  logic [OP_W-1:0]  unit_a, unit_b;
  logic [3:0]       unit_init;
  logic [3:0]       unit_done;
  logic [4*RES_W-1:0] unit_res;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_result;
  logic [1:0]       rsp_opcode;
  logic             rsp_err;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  alu_op_sequencer #(.OP_W(OP_W), .RES_W(RES_W), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .unit_a(unit_a), .unit_b(unit_b), .unit_init(unit_init),
    .unit_done(unit_done), .unit_res(unit_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_opcode(rsp_opcode), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_opcode = 2'b00; req_a = '0; req_b = '0;
    unit_done = 4'b0000; unit_res = '0; rsp_ready = 1'b0;
    step(); step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_init", unit_init, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_err", rsp_err, 0);
    rst = 1'b0;
    step();

    // sum 3+5
    req_valid = 1'b1; req_opcode = 2'b00; req_a = 3'd3; req_b = 3'd5;
    step();
    chk("sum_init", unit_init, 4'b0001);
    chk("sum_ready_low", req_ready, 0);
    chk("sum_busy", busy, 1);
    chk("sum_unit_a", unit_a, 3);
    chk("sum_unit_b", unit_b, 5);
    req_valid = 1'b0;
    step();
    chk("sum_init_one_cycle", unit_init, 0);
    chk("sum_no_rsp_in_wait", rsp_valid, 0);
    unit_done = 4'b0001; unit_res = {6'd0, 6'd0, 6'd0, 6'd8};
    step();
    unit_done = 4'b0000;
    chk("sum_rsp_valid", rsp_valid, 1);
    chk("sum_result", rsp_result, 8);
    chk("sum_opcode", rsp_opcode, 0);
    chk("sum_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("sum_rsp_done", rsp_valid, 0);
    chk("sum_ready_back", req_ready, 1);
    chk("sum_idle", busy, 0);

    // multiply 7*7 with slow done and stalled consumer
    req_valid = 1'b1; req_opcode = 2'b10; req_a = 3'd7; req_b = 3'd7;
    step();
    chk("mul_init", unit_init, 4'b0100);
    req_valid = 1'b0;
    unit_res = {6'd11, 6'd49, 6'd22, 6'd33};
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mul_wait_no_rsp", rsp_valid, 0);
    end
    unit_done = 4'b0100;
    step();
    unit_done = 4'b0000;
    req_valid = 1'b1; req_opcode = 2'b00; req_a = 3'd1; req_b = 3'd1;
    for (int i = 0; i < 3; i++) begin
      chk("mul_rsp_held", rsp_valid, 1);
      chk("mul_result", rsp_result, 49);
      chk("mul_opcode", rsp_opcode, 2);
      chk("mul_no_accept", req_ready, 0);
      chk("mul_no_init", unit_init, 0);
      chk("mul_unit_a_held", unit_a, 7);
      step();
    end
    req_valid = 1'b0;
    chk("mul_rsp_still", rsp_valid, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("mul_rsp_done", rsp_valid, 0);
    chk("mul_idle", busy, 0);

    // divide 6/2 with early done in ISSUE and a wrong-unit done in WAIT
    req_valid = 1'b1; req_opcode = 2'b11; req_a = 3'd6; req_b = 3'd2;
    step();
    chk("div_init", unit_init, 4'b1000);
    req_valid = 1'b0;
    unit_done = 4'b1000; unit_res = {6'd5, 6'd0, 6'd0, 6'd0};
    step();
    chk("div_issue_done_ignored", rsp_valid, 0);
    unit_done = 4'b0001; unit_res = {6'd5, 6'd0, 6'd0, 6'd63};
    step();
    chk("div_wrong_done_ignored", rsp_valid, 0);
    unit_done = 4'b1000; unit_res = {6'd3, 6'd0, 6'd0, 6'd63};
    step();
    unit_done = 4'b0000;
    chk("div_rsp_valid", rsp_valid, 1);
    chk("div_result", rsp_result, 3);
    chk("div_opcode", rsp_opcode, 3);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // reset in the middle of WAIT
    req_valid = 1'b1; req_opcode = 2'b01; req_a = 3'd4; req_b = 3'd1;
    step();
    req_valid = 1'b0;
    step(); step();
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    step();
    chk("midrst_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);
    step();
    rst = 1'b0;
    chk("midrst_init", unit_init, 0);
    chk("midrst_rsp", rsp_valid, 0);
    chk("midrst_unit_a", unit_a, 0);
    unit_done = 4'b0010; unit_res = {6'd0, 6'd0, 6'd3, 6'd0};
    step();
    unit_done = 4'b0000;
    step();
    chk("midrst_no_rsp_after", rsp_valid, 0);
    chk("midrst_still_idle", busy, 0);

    // subtract with a unit that never answers
    req_valid = 1'b1; req_opcode = 2'b01; req_a = 3'd5; req_b = 3'd2;
    unit_res = {6'd9, 6'd9, 6'd9, 6'd9};
    step();
    req_valid = 1'b0;
    step();
`ifdef ALU_SEQ_TIMEOUT_EN
    for (int i = 0; i < 63; i++) step();
    chk("to_not_yet", rsp_valid, 0);
    step();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_err", rsp_err, 1);
    chk("to_result", rsp_result, 0);
    chk("to_opcode", rsp_opcode, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("to_idle", busy, 0);
`else
    for (int i = 0; i < 100; i++) step();
    chk("hang_busy", busy, 1);
    chk("hang_no_rsp", rsp_valid, 0);
    chk("hang_err", rsp_err, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("hang_recover", req_ready, 1);
`endif

    // back-to-back with stuck-high done and an always-ready consumer
    unit_done = 4'b1111;
    unit_res  = {6'd7, 6'd30, 6'd4, 6'd9};
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int op = 0; op < 4; op++) begin
      logic [OP_W-1:0] ea, eb;
      logic [RES_W-1:0] er;
      case (op)
        0: begin ea = 3'd4; eb = 3'd5; er = 6'd9;  end
        1: begin ea = 3'd7; eb = 3'd3; er = 6'd4;  end
        2: begin ea = 3'd6; eb = 3'd5; er = 6'd30; end
        default: begin ea = 3'd7; eb = 3'd1; er = 6'd7; end
      endcase
      req_opcode = op[1:0]; req_a = ea; req_b = eb;
      chk("b2b_ready", req_ready, 1);
      step();
      chk("b2b_init", unit_init, 4'b0001 << op);
      chk("b2b_ready_low", req_ready, 0);
      req_opcode = 2'(op + 1); req_a = 3'd0; req_b = 3'd0;
      step();
      chk("b2b_no_reissue", unit_init, 0);
      step();
      chk("b2b_rsp_valid", rsp_valid, 1);
      chk("b2b_result", rsp_result, er);
      chk("b2b_opcode", rsp_opcode, op);
      chk("b2b_unit_a", unit_a, ea);
      chk("b2b_unit_b", unit_b, eb);
      step();
      chk("b2b_rsp_taken", rsp_valid, 0);
    end
    req_valid = 1'b0;
    step();
    chk("b2b_final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
